// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding and datapath width for the alu
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } opcode_t;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational logical barrel shifter, amount 0-7, with shifted-out bit
module alu_shifter
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [2:0]       amt,
    input  logic             right,
    output logic [ALU_W-1:0] y,
    output logic             out_bit
);

    logic [ALU_W:0] lext;
    logic [ALU_W:0] rext;

    // One guard bit catches the last bit shifted out; it stays 0 for amount 0.
    always_comb begin
        lext = {1'b0, a} << amt;
        rext = {a, 1'b0} >> amt;
        if (right) begin
            y       = rext[ALU_W:1];
            out_bit = rext[0];
        end else begin
            y       = lext[ALU_W-1:0];
            out_bit = lext[ALU_W];
        end
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit eight-function alu with registered result and status flags
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [2:0]       op,
    output logic [ALU_W-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    logic [ALU_W:0]   sum;
    logic [ALU_W:0]   diff;
    logic [ALU_W-1:0] sh_y;
    logic             sh_c;
    logic [ALU_W-1:0] res_d;
    logic             c_d;
    logic             v_d;

    // op[0] distinguishes SHR (111) from SHL (110).
    alu_shifter u_shifter (
        .a       (A),
        .amt     (B[2:0]),
        .right   (op[0]),
        .y       (sh_y),
        .out_bit (sh_c)
    );

    always_comb begin
        sum   = {1'b0, A} + {1'b0, B};
        diff  = {1'b0, A} - {1'b0, B};
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (opcode_t'(op))
            OP_ADD: begin
                res_d = sum[ALU_W-1:0];
                c_d   = sum[ALU_W];
                v_d   = (A[ALU_W-1] == B[ALU_W-1]) && (sum[ALU_W-1] != A[ALU_W-1]);
            end
            OP_SUB: begin
                res_d = diff[ALU_W-1:0];
                c_d   = diff[ALU_W];
                v_d   = (A[ALU_W-1] != B[ALU_W-1]) && (diff[ALU_W-1] != A[ALU_W-1]);
            end
            OP_AND: res_d = A & B;
            OP_OR:  res_d = A | B;
            OP_XOR: res_d = A ^ B;
            OP_NOT: res_d = ~A;
            OP_SHL, OP_SHR: begin
                res_d = sh_y;
                c_d   = sh_c;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
            negative <= 1'b0;
        end else begin
            result   <= res_d;
            carry    <= c_d;
            overflow <= v_d;
            zero     <= (res_d == '0);
            negative <= res_d[ALU_W-1];
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu with directed and random vectors
module tb_alu;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;

    int vectors = 0;
    int errors  = 0;
    sb_t sbq[$];

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .op       (op),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int r, input int c, input int v);
        exp_t e;
        int   rm;
        rm  = ((r % 256) + 256) % 256;
        e.r = rm[7:0];
        e.c = (c != 0);
        e.v = (v != 0);
        e.z = (rm == 0);
        e.n = (rm >= 128);
        return e;
    endfunction

    // Reference model from the opcode table, using plain integer arithmetic.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        int ai, bi, sa, sb, n, r, c, v;
        ai = a;
        bi = b;
        sa = (ai > 127) ? ai - 256 : ai;
        sb = (bi > 127) ? bi - 256 : bi;
        n  = bi % 8;
        c  = 0;
        v  = 0;
        case (o)
            3'd0: begin r = ai + bi; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin r = ai - bi; c = (ai < bi); v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: r = ai & bi;
            3'd3: r = ai | bi;
            3'd4: r = ai ^ bi;
            3'd5: r = 255 - ai;
            3'd6: begin r = ai * (2 ** n); c = (n == 0) ? 0 : (ai / (2 ** (8 - n))) % 2; end
            default: begin r = ai / (2 ** n); c = (n == 0) ? 0 : (ai / (2 ** (n - 1))) % 2; end
        endcase
        return mk(r, c, v);
    endfunction

    task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] o, input exp_t e, input string tag);
        sb_t s;
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        op  = o;
        s.e = e;
        s.tag = tag;
        sbq.push_back(s);
    endtask

    task automatic op_m(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o, input string tag);
        drive(1'b0, a, b, o, model(a, b, o), tag);
    endtask

    task automatic op_x(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                        input int r, input int c, input int v, input string tag);
        drive(1'b0, a, b, o, mk(r, c, v), tag);
    endtask

    task automatic do_rst(input string tag);
        drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), mk(0, 0, 0), tag);
    endtask

    // Monitor: one registered response per edge, compared against the oldest expectation.
    initial begin
        exp_t got;
        sb_t  s;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                s   = sbq.pop_front();
                got = '{r: result, c: carry, v: overflow, z: zero, n: negative};
                vectors++;
                if (got !== s.e) begin
                    errors++;
                    $display("FAIL %s: got r=%h c=%b v=%b z=%b n=%b, want r=%h c=%b v=%b z=%b n=%b",
                             s.tag, got.r, got.c, got.v, got.z, got.n,
                             s.e.r, s.e.c, s.e.v, s.e.z, s.e.n);
                end
            end
        end
    end

    initial begin
        int cyc;
        rst = 1'b1;
        A   = '0;
        B   = '0;
        op  = '0;
        do_rst("reset0");
        do_rst("reset1");

        op_x(8'h80, 8'h01, 3'd0, 8'h81, 0, 0, "sweep_add");
        op_x(8'h80, 8'h01, 3'd1, 8'h7F, 0, 1, "sweep_sub");
        op_x(8'h80, 8'h01, 3'd2, 8'h00, 0, 0, "sweep_and");
        op_x(8'h80, 8'h01, 3'd3, 8'h81, 0, 0, "sweep_or");
        op_x(8'h80, 8'h01, 3'd4, 8'h81, 0, 0, "sweep_xor");
        op_x(8'h80, 8'h01, 3'd5, 8'h7F, 0, 0, "sweep_not");
        op_x(8'h80, 8'h01, 3'd6, 8'h00, 1, 0, "sweep_shl");
        op_x(8'h80, 8'h01, 3'd7, 8'h40, 0, 0, "sweep_shr");

        op_x(8'hFF, 8'h01, 3'd0, 8'h00, 1, 0, "add_wrap");
        op_x(8'h7F, 8'h01, 3'd0, 8'h80, 0, 1, "add_ovf");
        op_x(8'h00, 8'h01, 3'd1, 8'hFF, 1, 0, "sub_borrow");
        op_x(8'h01, 8'h07, 3'd6, 8'h80, 0, 0, "shl_7");
        op_x(8'h81, 8'h00, 3'd7, 8'h81, 0, 0, "shr_0");
        op_x(8'h81, 8'h09, 3'd7, 8'h40, 1, 0, "shr_b9");
        op_x(8'h81, 8'h00, 3'd6, 8'h81, 0, 0, "shl_0");

        op_m(8'h12, 8'h34, 3'd0, "b2b_a");
        do_rst("mid_reset");
        op_m(8'hC3, 8'h5A, 3'd1, "after_reset");

        for (int i = 0; i < 200; i++) begin
            logic [7:0] a, b;
            logic [2:0] o;
            a = 8'($urandom);
            b = 8'($urandom);
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0)
                do_rst("rand_reset");
            else
                op_m(a, b, o, "random");
        end

        cyc = 0;
        while (sbq.size() > 0 && cyc < 10) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

8-bit, eight-function arithmetic/logic unit with a registered result and status flags. It sits in the datapath as a single-cycle execute stage. Operands and opcode are sampled on a clock edge, and the result and flags are held in output registers until the next edge. It has no internal state beyond those output registers.

## Interface
Parameters: none. Width is fixed at 8 bits.

Ports:
- `clk` — input, 1 bit. Single clock; all registers update on its rising edge.
- `rst` — input, 1 bit. Synchronous, active-high reset.
- `A` — input, 8 bits. Operand A.
- `B` — input, 8 bits. Operand B. For shift opcodes only `B[2:0]` is used, as the shift amount.
- `op` — input, 3 bits. Opcode.
- `result` — output, 8 bits. Registered result.
- `carry` — output, 1 bit. Registered carry, borrow, or shifted-out bit.
- `overflow` — output, 1 bit. Registered two's-complement overflow.
- `zero` — output, 1 bit. Registered flag, 1 when `result == 0`.
- `negative` — output, 1 bit. Registered copy of `result[7]`.

## Operation
Opcode decode:
- `000` ADD: `result = A + B`; `carry` = bit 8 of the sum; `overflow` = 1 when `A` and `B` have the same sign and the result sign differs.
- `001` SUB: `result = A - B`; `carry` = borrow, i.e. 1 when `A < B` unsigned; `overflow` = 1 when `A` and `B` differ in sign and the result sign differs from `A`.
- `010` AND: `A & B`.
- `011` OR: `A | B`.
- `100` XOR: `A ^ B`.
- `101` NOT: `~A`; `B` is ignored.
- `110` SHL: logical left shift of `A` by `B[2:0]`, zero fill; `carry` = last bit shifted out, which is `A[8-B[2:0]]`.
- `111` SHR: logical right shift of `A` by `B[2:0]`, zero fill; `carry` = last bit shifted out, which is `A[B[2:0]-1]`.

Flag rules:
- `carry` = 0 and `overflow` = 0 for AND, OR, XOR and NOT.
- `overflow` = 0 for both shifts.
- Shift amount 0 gives `result = A` and `carry = 0`.
- `zero` and `negative` are derived from the new result for every opcode.
- All arithmetic is modulo 2^8. No saturation.
- Every `op` value is defined, so there is no illegal-opcode behaviour.

## Timing
- Latency is 1 cycle. Inputs present at rising edge N appear on the outputs after edge N and hold until edge N+1.
- Outputs change only at rising edges of `clk`. They are never combinational from the inputs.
- Reset: when `rst` is 1 at a rising edge, `result` = `0x00`, `carry` = 0, `overflow` = 0, `negative` = 0 and `zero` = 1, since the flag is consistent with a zero result.
- Reset overrides any operation on the same edge.
- A new operation is accepted every cycle. There is no handshake, no stall, and no back-pressure.
- Changing `op`, `A` or `B` mid-cycle has no effect until the next edge.

## Structure
- Shared package `alu_pkg` holds:
  - the 3-bit opcode enum: `OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOT=5, OP_SHL=6, OP_SHR=7`;
  - the constant `ALU_W = 8`.
- One sub-module is natural: `alu_shifter`, a combinational barrel shifter for left and right shifts, amount 0–7, with a shifted-out bit output.
- Everything else is one combinational case statement feeding a single output register stage.

## Test plan
- Reset: assert `rst` for 2 cycles with arbitrary inputs → `result` = `0x00`, `zero` = 1, all other flags 0.
- Opcode sweep with `A=0x80`, `B=0x01`, `op` stepping `000`..`111` one per cycle. Each result appears one cycle after its opcode is applied:
  - ADD → `0x81`, `n=1`
  - SUB → `0x7F`, `v=1`, `c=0`
  - AND → `0x00`, `z=1`
  - OR → `0x81`
  - XOR → `0x81`
  - NOT → `0x7F`
  - SHL → `0x00`, `c=1`, `z=1`
  - SHR → `0x40`, `c=0`
- ADD `0xFF + 0x01` → `0x00`, `c=1`, `z=1`, `v=0`. ADD `0x7F + 0x01` → `0x80`, `v=1`, `n=1`.
- SUB `0x00 - 0x01` → `0xFF`, `c=1`, `n=1`, `v=0`.
- Shift amounts:
  - SHL `A=0x01`, `B=0x07` → `0x80`.
  - SHR `A=0x81`, `B=0x00` → `0x81`, `c=0`.
  - SHR `A=0x81`, `B=0x09` → uses only `B[2:0]=1`, giving `0x40`, `c=1`.
- Assert `rst` in the middle of back-to-back operations → outputs go to reset values on that edge, and the next operation after `rst` deasserts produces correct results.
